uart_rx_word_packer: RTL

//  Downstream consumer of the UART RX stage. Packs NBYTES consecutive received

---
 rtl/uart_rx_word_packer.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_rx_word_packer.sv
// Packs NBYTES received UART bytes into one word behind a valid/ready handshake.
// Drops partial words after a silence timeout and flags bytes lost while holding.
module uart_rx_word_packer #(
    parameter int NBITS         = 8,
    parameter int NBYTES        = 4,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_baud_rate,
    input  logic                    i_rx_done,
    input  logic [NBITS-1:0]        i_rx_data,
    input  logic                    i_word_ready,
    output logic [NBITS*NBYTES-1:0] o_word,
    output logic                    o_word_valid,
    output logic                    o_timeout,
    output logic                    o_overrun
);
    localparam int WW = NBITS * NBYTES;
    localparam int CW = $clog2(NBYTES);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] tcnt_q, tcnt_n;
    logic [WW-1:0] word_q, word_n;
    logic          to_q, to_n;
    logic          ov_q, ov_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            word_q  <= '0;
            to_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            tcnt_q  <= tcnt_n;
            word_q  <= word_n;
            to_q    <= to_n;
            ov_q    <= ov_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        tcnt_n  = tcnt_q;
        word_n  = word_q;
        to_n    = 1'b0;
        ov_n    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (i_rx_done) begin
                    word_n[cnt_q*NBITS +: NBITS] = i_rx_data;
                    tcnt_n = '0;
                    if (cnt_q == LAST) begin
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end else if (cnt_q != '0 && i_baud_rate) begin
                    // A byte arriving on the terminal tick takes the branch above.
                    if (tcnt_q == TERM) begin
                        cnt_n  = '0;
                        tcnt_n = '0;
                        word_n = '0;
                        to_n   = 1'b1;
                    end else begin
                        tcnt_n = tcnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_word_ready) begin
                    state_n = COLLECT;
                    if (i_rx_done) begin
                        word_n[NBITS-1:0] = i_rx_data;
                        cnt_n  = CW'(1);
                        tcnt_n = '0;
                    end
                end else if (i_rx_done) begin
                    ov_n = 1'b1;
                end
            end
        endcase
    end

    assign o_word       = word_q;
    assign o_word_valid = (state_q == HOLD);
    assign o_timeout    = to_q;
    assign o_overrun    = ov_q;
endmodule
